ddr2_init_sequencer: RTL and testbench

Runs the JEDEC DDR2 power-up and mode-register initialization sequence for the DRAM controller. It sits directly downstream of the DRAM clock/reset infrastructure, clocked by its divided controller clock (`dram_clk_div`, half the DRAM clock). It drives the DRAM command path and clock-enable until initialization completes. When `init_done` rises, the controller's normal read/write/refresh scheduler takes over the command interface.

---
 rtl/ddr2_init_pkg.sv | 32 +++
 rtl/ddr2_init_timer.sv | 26 ++
 rtl/ddr2_init_sequencer.sv | 166 ++++++++++++++++
 tb/tb_ddr2_init_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_init_pkg.sv
// Shared definitions for the DDR2 power-up / mode-register initialization sequencer.
package ddr2_init_pkg;

    // Command encodings as {ras_n, cas_n, we_n}; chip select is implicitly asserted.
    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_MRS = 3'b000;

    // Eleven ROM steps (0..10); init_step reads 11 once the sequence is complete.
    localparam int         NUM_STEPS = 11;
    localparam logic [3:0] LAST_STEP = 4'(NUM_STEPS - 1);
    localparam logic [3:0] DONE_STEP = 4'(NUM_STEPS);

    // Mode-register bit masks.
    localparam int unsigned MR_DLL_RESET   = 32'h100;
    localparam int unsigned MR_OCD_DEFAULT = 32'h380;
    localparam int unsigned MR_A10         = 32'h400;

    typedef enum logic [2:0] {
        ST_RST_WAIT,
        ST_CKE_WAIT,
        ST_ISSUE,
        ST_GAP,
        ST_DONE
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr2_init_timer.sv
// Loadable down-counter shared by every wait of the init sequence.
// It stops at zero, so a stale count never wraps into a bogus long wait.
module ddr2_init_timer #(
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             expired
);

    // Load a new wait, otherwise count down and hold at zero.
    // NOTE: no reset here on purpose; the owner asserts load while in reset,
    // so the count is always defined before anyone looks at it.
    always_ff @(posedge clk) begin
        if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign expired = (value == '0);

endmodule

// File: rtl/ddr2_init_sequencer.sv
// DDR2 JEDEC power-up and mode-register initialization sequencer.
// Holds CKE low, raises it, then walks an 11-step command ROM with a
// valid/ready handshake, spacing commands by each step's gap.
module ddr2_init_sequencer
    import ddr2_init_pkg::*;
#(
    parameter int                  ROW_WIDTH  = 14,
    parameter int                  T_INIT     = 26600,
    parameter int                  T_CKE      = 54,
    parameter int                  T_RP       = 2,
    parameter int                  T_MRD      = 2,
    parameter int                  T_RFC      = 17,
    parameter int                  T_DLL      = 100,
    parameter logic [ROW_WIDTH-1:0] MR_VALUE   = 14'h0652,
    parameter logic [ROW_WIDTH-1:0] EMR1_VALUE = 14'h0004
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic                 cmd_ras_n,
    output logic                 cmd_cas_n,
    output logic                 cmd_we_n,
    output logic [2:0]           cmd_ba,
    output logic [ROW_WIDTH-1:0] cmd_addr,
    output logic                 ddr_cke,
    output logic                 init_done,
    output logic [3:0]           init_step
);

    // Counter is sized for the longest wait; T_INIT dominates in any real configuration.
    localparam int MAX_WAIT = max2(max2(max2(T_INIT, T_CKE), max2(T_RP, T_MRD)), max2(T_RFC, T_DLL));
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    state_t                 state_q, state_d;
    logic [3:0]             step_q, step_d;
    logic                   tmr_load;
    logic [CNT_W-1:0]       tmr_load_value;
    logic [CNT_W-1:0]       tmr_value_unused;   // remaining count; only expiry matters here
    logic                   tmr_expired;

    logic [2:0]             rom_cmd;
    logic [2:0]             rom_ba;
    logic [ROW_WIDTH-1:0]   rom_addr;
    logic [31:0]            rom_gap;

    ddr2_init_timer #(.WIDTH(CNT_W)) u_timer (
        .clk        (clk),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .value      (tmr_value_unused),
        .expired    (tmr_expired)
    );

    // Step ROM: command, bank, address and post-command gap for the current step.
    always_comb begin
        rom_cmd  = CMD_NOP;
        rom_ba   = 3'd0;
        rom_addr = '0;
        rom_gap  = 32'd1;
        case (step_q)
            4'd0:  begin rom_cmd = CMD_PRE; rom_addr = ROW_WIDTH'(MR_A10);                       rom_gap = T_RP;  end
            4'd1:  begin rom_cmd = CMD_MRS; rom_ba = 3'd2;                                       rom_gap = T_MRD; end
            4'd2:  begin rom_cmd = CMD_MRS; rom_ba = 3'd3;                                       rom_gap = T_MRD; end
            4'd3:  begin rom_cmd = CMD_MRS; rom_ba = 3'd1; rom_addr = EMR1_VALUE;                rom_gap = T_MRD; end
            4'd4:  begin rom_cmd = CMD_MRS; rom_addr = MR_VALUE | ROW_WIDTH'(MR_DLL_RESET);      rom_gap = T_MRD; end
            4'd5:  begin rom_cmd = CMD_PRE; rom_addr = ROW_WIDTH'(MR_A10);                       rom_gap = T_RP;  end
            4'd6:  begin rom_cmd = CMD_REF;                                                      rom_gap = T_RFC; end
            4'd7:  begin rom_cmd = CMD_REF;                                                      rom_gap = T_RFC; end
            4'd8:  begin rom_cmd = CMD_MRS; rom_addr = MR_VALUE;                                 rom_gap = T_DLL; end
            4'd9:  begin rom_cmd = CMD_MRS; rom_ba = 3'd1; rom_addr = EMR1_VALUE | ROW_WIDTH'(MR_OCD_DEFAULT); rom_gap = T_MRD; end
            4'd10: begin rom_cmd = CMD_MRS; rom_ba = 3'd1; rom_addr = EMR1_VALUE;                rom_gap = T_MRD; end
            default: ;
        endcase
    end

    // State and step registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_RST_WAIT;
            step_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Next-state logic and timer loads. The ISSUE cycle itself counts as the
    // first gap cycle, so GAP lasts gap-1 cycles and a gap of 1 skips GAP.
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        step_d         = step_q;
        tmr_load       = 1'b0;
        tmr_load_value = '0;
        case (state_q)
            ST_RST_WAIT: begin
                if (tmr_expired) begin
                    state_d        = ST_CKE_WAIT;
                    tmr_load       = 1'b1;
                    tmr_load_value = CNT_W'(T_CKE - 1);
                end
            end
            ST_CKE_WAIT: begin
                if (tmr_expired) begin
                    state_d = ST_ISSUE;
                    step_d  = 4'd0;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    if (rom_gap > 32'd1) begin
                        state_d        = ST_GAP;
                        tmr_load       = 1'b1;
                        tmr_load_value = CNT_W'(rom_gap - 32'd2);
                    end else if (step_q == LAST_STEP) begin
                        state_d = ST_DONE;
                        step_d  = DONE_STEP;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
            end
            ST_GAP: begin
                if (tmr_expired) begin
                    if (step_q == LAST_STEP) begin
                        state_d = ST_DONE;
                        step_d  = DONE_STEP;
                    end else begin
                        state_d = ST_ISSUE;
                        step_d  = step_q + 4'd1;
                    end
                end
            end
            ST_DONE: ;
            default: state_d = ST_RST_WAIT;
        endcase
        // Reset arms the CKE-low hold so it runs from the first cycle out of reset.
        if (!reset_n) begin
            tmr_load       = 1'b1;
            tmr_load_value = CNT_W'(T_INIT);
        end
    end

    // Outputs decode from registered state: the command is only shown in ISSUE.
    always_comb begin
        cmd_valid                          = 1'b0;
        {cmd_ras_n, cmd_cas_n, cmd_we_n}   = CMD_NOP;
        cmd_ba                             = 3'd0;
        cmd_addr                           = '0;
        if (state_q == ST_ISSUE) begin
            cmd_valid                        = 1'b1;
            {cmd_ras_n, cmd_cas_n, cmd_we_n} = rom_cmd;
            cmd_ba                           = rom_ba;
            cmd_addr                         = rom_addr;
        end
    end

    assign ddr_cke   = (state_q != ST_RST_WAIT);
    assign init_done = (state_q == ST_DONE);
    assign init_step = step_q;

endmodule

// File: tb/tb_ddr2_init_sequencer.sv
// Directed self-checking bench for ddr2_init_sequencer. Cycle c is the clock
// period after the c-th edge with reset_n high (cycle 0 follows the first one).
module tb_ddr2_init_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic cmd_ready = 1'b1;
    logic sel = 1'b0;          // 0: nominal-timing DUT, 1: minimum-timing DUT

    always #5 clk = ~clk;

    // Nominal-timing DUT
    logic        n_valid, n_ras, n_cas, n_we, n_cke, n_done;
    logic [2:0]  n_ba;
    logic [13:0] n_addr;
    logic [3:0]  n_step;
    // Minimum-timing DUT
    logic        m_valid, m_ras, m_cas, m_we, m_cke, m_done;
    logic [2:0]  m_ba;
    logic [13:0] m_addr;
    logic [3:0]  m_step;

    ddr2_init_sequencer #(.T_INIT(10), .T_CKE(4)) u_nom (
        .clk(clk), .reset_n(reset_n), .cmd_valid(n_valid), .cmd_ready(cmd_ready),
        .cmd_ras_n(n_ras), .cmd_cas_n(n_cas), .cmd_we_n(n_we), .cmd_ba(n_ba),
        .cmd_addr(n_addr), .ddr_cke(n_cke), .init_done(n_done), .init_step(n_step)
    );

    ddr2_init_sequencer #(.T_INIT(1), .T_CKE(1), .T_RP(1), .T_MRD(1), .T_RFC(1), .T_DLL(1)) u_min (
        .clk(clk), .reset_n(reset_n), .cmd_valid(m_valid), .cmd_ready(cmd_ready),
        .cmd_ras_n(m_ras), .cmd_cas_n(m_cas), .cmd_we_n(m_we), .cmd_ba(m_ba),
        .cmd_addr(m_addr), .ddr_cke(m_cke), .init_done(m_done), .init_step(m_step)
    );

    logic        obs_valid, obs_cke, obs_done;
    logic [2:0]  obs_cmd, obs_ba;
    logic [13:0] obs_addr;
    logic [3:0]  obs_step;
    assign obs_valid = sel ? m_valid : n_valid;
    assign obs_cke   = sel ? m_cke   : n_cke;
    assign obs_done  = sel ? m_done  : n_done;
    assign obs_cmd   = sel ? {m_ras, m_cas, m_we} : {n_ras, n_cas, n_we};
    assign obs_ba    = sel ? m_ba    : n_ba;
    assign obs_addr  = sel ? m_addr  : n_addr;
    assign obs_step  = sel ? m_step  : n_step;

    int n_pass = 0;
    int n_total = 0;

    // Hand-computed ROM payloads for MR=0x652, EMR1=0x004.
    logic [2:0]  exp_cmd  [0:10] = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010,
                                     3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
    logic [2:0]  exp_ba   [0:10] = '{3'd0, 3'd2, 3'd3, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
    logic [13:0] exp_addr [0:10] = '{14'h400, 14'h000, 14'h000, 14'h004, 14'h752, 14'h400,
                                     14'h000, 14'h000, 14'h652, 14'h384, 14'h004};
    int          gap_nom  [0:10] = '{2, 2, 2, 2, 2, 2, 17, 17, 100, 2, 2};

    int exp_cycle [0:10];
    int exp_done;

    // Recorded run results
    int          x_cycle [0:15];
    logic [2:0]  x_cmd   [0:15];
    logic [2:0]  x_ba    [0:15];
    logic [13:0] x_addr  [0:15];
    logic [3:0]  x_step  [0:15];
    int          n_xfer, cke_cycle, done_cycle, stab_err, idle_err, cke_err, end_step;
    bit          done_fell;

    // Expected transfer cycles: first command T_INIT+T_CKE, then gap(n) apart,
    // plus any stall inserted on one step.
    task automatic build_expected(input int t_init, input int t_cke, input bit minimal,
                                  input int bp_step, input int bp_len);
        int c;
        c = t_init + t_cke;
        for (int n = 0; n < 11; n++) begin
            if (n == bp_step) c = c + bp_len;
            exp_cycle[n] = c;
            c = c + (minimal ? 1 : gap_nom[n]);
        end
        exp_done = c;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset_n   = 1'b0;
        cmd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Release reset and watch the selected DUT until shortly after init_done
    // (or the cycle budget runs out). Optionally stall one step or reset on one step.
    task automatic run_seq(input int max_cycles, input int bp_step, input int bp_len,
                           input int rst_step, output bit rst_hit);
        int          stall, post;
        logic        pv, pxfer;
        logic [2:0]  pc, pba;
        logic [13:0] paddr;
        logic [3:0]  pstep;
        n_xfer = 0; cke_cycle = -1; done_cycle = -1; stab_err = 0; idle_err = 0;
        cke_err = 0; done_fell = 0; end_step = -1; rst_hit = 0;
        stall = 0; post = 0; pv = 0; pxfer = 0; pc = 0; pba = 0; paddr = 0; pstep = 0;
        reset_n = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            @(posedge clk); #1;
            cmd_ready = 1'b1;
            if (obs_valid && (int'(obs_step) == bp_step) && stall < bp_len) begin
                cmd_ready = 1'b0;
                stall++;
            end
            if (pv && !pxfer && (!obs_valid || obs_cmd != pc || obs_ba != pba ||
                                 obs_addr != paddr || obs_step != pstep)) stab_err++;
            if (!obs_valid && (obs_cmd != 3'b111 || obs_ba != 3'd0 || obs_addr != 14'd0)) idle_err++;
            if (obs_cke && cke_cycle < 0) cke_cycle = c;
            if (!obs_cke && cke_cycle >= 0) cke_err++;
            if (obs_done && done_cycle < 0) done_cycle = c;
            if (!obs_done && done_cycle >= 0) done_fell = 1;
            if (obs_valid && int'(obs_step) == rst_step) begin
                reset_n = 1'b0;
                rst_hit = 1;
                break;
            end
            pxfer = obs_valid && cmd_ready;
            if (pxfer && n_xfer < 16) begin
                x_cycle[n_xfer] = c;
                x_cmd[n_xfer]   = obs_cmd;
                x_ba[n_xfer]    = obs_ba;
                x_addr[n_xfer]  = obs_addr;
                x_step[n_xfer]  = obs_step;
                n_xfer++;
            end
            pv = obs_valid; pc = obs_cmd; pba = obs_ba; paddr = obs_addr; pstep = obs_step;
            if (done_cycle >= 0) begin
                post++;
                end_step = int'(obs_step);
                if (post >= 5) break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++; if (obs_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", obs_valid); else n_pass++;
        n_total++; if (obs_cmd !== 3'b111) $display("FAIL reset_cmd got=%b want=111", obs_cmd); else n_pass++;
        n_total++; if (obs_ba !== 3'd0) $display("FAIL reset_ba got=%0d want=0", obs_ba); else n_pass++;
        n_total++; if (obs_addr !== 14'd0) $display("FAIL reset_addr got=%h want=0", obs_addr); else n_pass++;
        n_total++; if (obs_cke !== 1'b0) $display("FAIL reset_cke got=%b want=0", obs_cke); else n_pass++;
        n_total++; if (obs_done !== 1'b0) $display("FAIL reset_done got=%b want=0", obs_done); else n_pass++;
        n_total++; if (obs_step !== 4'd0) $display("FAIL reset_step got=%0d want=0", obs_step); else n_pass++;
    endtask

    task automatic test_nominal();
        bit hit;
        build_expected(10, 4, 0, -1, 0);
        run_seq(400, -1, 0, -1, hit);
        n_total++; if (cke_cycle != 10) $display("FAIL nom_cke_rise got=%0d want=10", cke_cycle); else n_pass++;
        n_total++; if (n_xfer != 11) $display("FAIL nom_xfer_count got=%0d want=11", n_xfer); else n_pass++;
        for (int n = 0; n < 11; n++) begin
            n_total++;
            if (x_cycle[n] != exp_cycle[n] || x_cmd[n] !== exp_cmd[n] || x_ba[n] !== exp_ba[n] ||
                x_addr[n] !== exp_addr[n] || x_step[n] !== 4'(n))
                $display("FAIL nom_step%0d got cyc=%0d cmd=%b ba=%0d addr=%h step=%0d want cyc=%0d cmd=%b ba=%0d addr=%h step=%0d",
                         n, x_cycle[n], x_cmd[n], x_ba[n], x_addr[n], x_step[n],
                         exp_cycle[n], exp_cmd[n], exp_ba[n], exp_addr[n], n);
            else n_pass++;
        end
        n_total++; if (done_cycle != exp_done) $display("FAIL nom_done got=%0d want=%0d", done_cycle, exp_done); else n_pass++;
        n_total++; if (end_step != 11) $display("FAIL nom_done_step got=%0d want=11", end_step); else n_pass++;
        n_total++; if (done_fell) $display("FAIL nom_done_sticky got=fell want=held"); else n_pass++;
        n_total++; if (idle_err != 0) $display("FAIL nom_idle_nop got=%0d want=0", idle_err); else n_pass++;
        n_total++; if (cke_err != 0) $display("FAIL nom_cke_held got=%0d want=0", cke_err); else n_pass++;
    endtask

    // Uses the transfers recorded by the nominal run.
    task automatic test_gaps();
        n_total++; if (x_cycle[7] - x_cycle[6] != 17) $display("FAIL gap_rfc got=%0d want=17", x_cycle[7] - x_cycle[6]); else n_pass++;
        n_total++; if (x_cycle[9] - x_cycle[8] != 100) $display("FAIL gap_dll got=%0d want=100", x_cycle[9] - x_cycle[8]); else n_pass++;
    endtask

    task automatic test_reset_after_done();
        bit hit;
        reset_n = 1'b0;
        @(posedge clk); #1;
        n_total++; if (obs_done !== 1'b0) $display("FAIL rdone_done_clear got=%b want=0", obs_done); else n_pass++;
        n_total++; if (obs_step !== 4'd0) $display("FAIL rdone_step got=%0d want=0", obs_step); else n_pass++;
        build_expected(10, 4, 0, -1, 0);
        run_seq(400, -1, 0, -1, hit);
        n_total++; if (n_xfer != 11 || x_cycle[0] != exp_cycle[0] || x_cycle[10] != exp_cycle[10])
            $display("FAIL rdone_rerun got n=%0d first=%0d last=%0d want n=11 first=%0d last=%0d",
                     n_xfer, x_cycle[0], x_cycle[10], exp_cycle[0], exp_cycle[10]);
        else n_pass++;
        n_total++; if (done_cycle != exp_done) $display("FAIL rdone_done got=%0d want=%0d", done_cycle, exp_done); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit hit;
        apply_reset();
        build_expected(10, 4, 0, 4, 7);
        run_seq(400, 4, 7, -1, hit);
        n_total++; if (stab_err != 0) $display("FAIL bp_stable got=%0d want=0", stab_err); else n_pass++;
        n_total++; if (x_cycle[4] != exp_cycle[4] || x_ba[4] !== 3'd0 || x_addr[4] !== 14'h752)
            $display("FAIL bp_step4 got cyc=%0d ba=%0d addr=%h want cyc=%0d ba=0 addr=752",
                     x_cycle[4], x_ba[4], x_addr[4], exp_cycle[4]);
        else n_pass++;
        n_total++; if (x_cycle[5] != exp_cycle[5]) $display("FAIL bp_step5 got=%0d want=%0d", x_cycle[5], exp_cycle[5]); else n_pass++;
        n_total++; if (n_xfer != 11) $display("FAIL bp_count got=%0d want=11", n_xfer); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit hit;
        apply_reset();
        run_seq(400, -1, 0, 3, hit);
        n_total++; if (!hit) $display("FAIL mid_reached_step3 got=0 want=1"); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (obs_valid !== 1'b0) $display("FAIL mid_valid got=%b want=0", obs_valid); else n_pass++;
        n_total++; if (obs_cke !== 1'b0) $display("FAIL mid_cke got=%b want=0", obs_cke); else n_pass++;
        n_total++; if (obs_step !== 4'd0) $display("FAIL mid_step got=%0d want=0", obs_step); else n_pass++;
        build_expected(10, 4, 0, -1, 0);
        run_seq(400, -1, 0, -1, hit);
        n_total++; if (cke_cycle != 10) $display("FAIL mid_cke_rise got=%0d want=10", cke_cycle); else n_pass++;
        n_total++; if (n_xfer != 11 || x_cycle[0] != exp_cycle[0] || x_cycle[10] != exp_cycle[10])
            $display("FAIL mid_rerun got n=%0d first=%0d last=%0d want n=11 first=%0d last=%0d",
                     n_xfer, x_cycle[0], x_cycle[10], exp_cycle[0], exp_cycle[10]);
        else n_pass++;
    endtask

    task automatic test_min_gaps();
        bit hit;
        sel = 1'b1;
        apply_reset();
        build_expected(1, 1, 1, -1, 0);
        run_seq(100, -1, 0, -1, hit);
        n_total++; if (cke_cycle != 1) $display("FAIL min_cke_rise got=%0d want=1", cke_cycle); else n_pass++;
        n_total++; if (n_xfer != 11) $display("FAIL min_xfer_count got=%0d want=11", n_xfer); else n_pass++;
        for (int n = 0; n < 11; n++) begin
            n_total++;
            if (x_cycle[n] != exp_cycle[n] || x_step[n] !== 4'(n) || x_cmd[n] !== exp_cmd[n] || x_addr[n] !== exp_addr[n])
                $display("FAIL min_step%0d got cyc=%0d step=%0d cmd=%b addr=%h want cyc=%0d step=%0d cmd=%b addr=%h",
                         n, x_cycle[n], x_step[n], x_cmd[n], x_addr[n], exp_cycle[n], n, exp_cmd[n], exp_addr[n]);
            else n_pass++;
        end
        n_total++; if (done_cycle != exp_done) $display("FAIL min_done got=%0d want=%0d", done_cycle, exp_done); else n_pass++;
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_gaps();
        test_reset_after_done();
        test_backpressure();
        test_reset_mid();
        test_min_gaps();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
